servo_pwm_multi: RTL and testbench

Multi-channel hobby-servo pulse generator. It is the parametrised successor to the single servotester top, and sits behind the Tiny Tapeout wrapper, which maps `ui_in`/`uio_in` onto its write port and `uo_out` onto `pwm_out`. Each channel produces one pulse per frame, with a width of `BASE_TICKS + pos` ticks. Each channel has its own mode: off, manual, center, or auto-sweep. Settings are double-buffered so that pulse widths only change on frame boundaries.

---
 rtl/servo_pwm_multi.sv | 144 ++++++++++++++
 tb/tb_servo_pwm_multi.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/servo_pwm_multi.sv
// ============================================================================
// servo_pwm_multi : multi-channel hobby-servo pulse generator with
//                   double-buffered per-channel mode/position settings.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module servo_pwm_multi #(
  parameter int CHANNELS    = 4,
  parameter int PRESCALE    = 40,
  parameter int FRAME_TICKS = 5000,
  parameter int BASE_TICKS  = 250,
  parameter int SWEEP_STEP  = 4,
  localparam int C_CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                wr_en,
  input  logic [C_CW-1:0]     wr_ch,
  input  logic [1:0]          wr_mode,
  input  logic [7:0]          wr_pos,
  input  logic [C_CW-1:0]     rd_ch,
  output logic [7:0]          rd_pos,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                frame_start
);

  localparam int C_PW   = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int C_FW   = (FRAME_TICKS > 1) ? $clog2(FRAME_TICKS) : 1;
  localparam int C_CMPW = C_FW + 1;

  localparam logic [C_PW-1:0]   C_PRE_MAX   = C_PW'(PRESCALE - 1);
  localparam logic [C_FW-1:0]   C_FRAME_MAX = C_FW'(FRAME_TICKS - 1);
  localparam logic [C_CMPW-1:0] C_BASE      = C_CMPW'(BASE_TICKS);
  localparam logic [8:0]        C_STEP9     = 9'(SWEEP_STEP);
  localparam logic [7:0]        C_STEP8     = 8'(SWEEP_STEP);

  localparam logic [1:0] C_MODE_OFF = 2'b00;
  localparam logic [1:0] C_MODE_CEN = 2'b10;
  localparam logic [1:0] C_MODE_SWP = 2'b11;

  logic [C_PW-1:0]           pre_cnt_q, pre_cnt_d;
  logic [C_FW-1:0]           frame_cnt_q, frame_cnt_d;
  logic [CHANNELS-1:0][1:0]  sh_mode_q, sh_mode_d, act_mode_q, act_mode_d;
  logic [CHANNELS-1:0][7:0]  sh_pos_q, sh_pos_d, act_pos_q, act_pos_d;
  logic [CHANNELS-1:0]       dirty_q, dirty_d, dir_q, dir_d;
  logic [CHANNELS-1:0]       pwm_q, pwm_d;
  logic                      frame_start_q;
  logic [CHANNELS-1:0][8:0]  w_up;
  logic                      w_tick, w_bnd;

  assign w_tick = (pre_cnt_q == C_PRE_MAX);
  assign w_bnd  = w_tick && (frame_cnt_q == C_FRAME_MAX);

  generate
    for (genvar g = 0; g < CHANNELS; g++) begin : g_sweep
      assign w_up[g] = {1'b0, act_pos_q[g]} + C_STEP9;
    end
  endgenerate

  // Outputs are computed from next-state values so the pulse rises together
  // with frame_start and already reflects settings latched at the boundary.
  always_comb begin
    pre_cnt_d   = w_tick ? '0 : pre_cnt_q + C_PW'(1);
    frame_cnt_d = frame_cnt_q;
    if (w_bnd)       frame_cnt_d = '0;
    else if (w_tick) frame_cnt_d = frame_cnt_q + C_FW'(1);
    sh_mode_d  = sh_mode_q;
    sh_pos_d   = sh_pos_q;
    dirty_d    = dirty_q;
    act_mode_d = act_mode_q;
    act_pos_d  = act_pos_q;
    dir_d      = dir_q;
    pwm_d      = '0;
    rd_pos     = 8'd0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (w_bnd) begin
        if (dirty_q[i]) begin
          act_mode_d[i] = sh_mode_q[i];
          act_pos_d[i]  = (sh_mode_q[i] == C_MODE_CEN) ? 8'd128 : sh_pos_q[i];
          dir_d[i]      = 1'b0;
          dirty_d[i]    = 1'b0;
        end else if (act_mode_q[i] == C_MODE_SWP) begin
          if (!dir_q[i]) begin
            if (w_up[i][8]) begin
              act_pos_d[i] = 8'd255;
              dir_d[i]     = 1'b1;
            end else begin
              act_pos_d[i] = w_up[i][7:0];
            end
          end else if (act_pos_q[i] < C_STEP8) begin
            act_pos_d[i] = 8'd0;
            dir_d[i]     = 1'b0;
          end else begin
            act_pos_d[i] = act_pos_q[i] - C_STEP8;
          end
        end
      end
      // A write in the boundary cycle lands after the old shadow is consumed.
      if (wr_en && (wr_ch == C_CW'(i))) begin
        sh_mode_d[i] = wr_mode;
        sh_pos_d[i]  = wr_pos;
        dirty_d[i]   = 1'b1;
      end
      pwm_d[i] = (act_mode_d[i] != C_MODE_OFF) &&
                 (C_CMPW'(frame_cnt_d) < (C_BASE + C_CMPW'(act_pos_d[i])));
      if (rd_ch == C_CW'(i)) rd_pos = act_pos_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_cnt_q     <= '0;
      frame_cnt_q   <= '0;
      dirty_q       <= '0;
      dir_q         <= '0;
      pwm_q         <= '0;
      frame_start_q <= 1'b0;
      for (int i = 0; i < CHANNELS; i++) begin
        sh_mode_q[i]  <= C_MODE_OFF;
        act_mode_q[i] <= C_MODE_OFF;
        sh_pos_q[i]   <= 8'd128;
        act_pos_q[i]  <= 8'd128;
      end
    end else begin
      pre_cnt_q     <= pre_cnt_d;
      frame_cnt_q   <= frame_cnt_d;
      sh_mode_q     <= sh_mode_d;
      sh_pos_q      <= sh_pos_d;
      dirty_q       <= dirty_d;
      act_mode_q    <= act_mode_d;
      act_pos_q     <= act_pos_d;
      dir_q         <= dir_d;
      pwm_q         <= pwm_d;
      frame_start_q <= w_bnd;
    end
  end

  assign pwm_out     = pwm_q;
  assign frame_start = frame_start_q;

endmodule

`default_nettype wire

// File: tb/tb_servo_pwm_multi.sv
// ============================================================================
// tb_servo_pwm_multi : directed scoreboard bench for servo_pwm_multi.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_servo_pwm_multi;

  localparam int C_FRAME_CYC = 800;

  typedef struct packed {
    logic [2:0][15:0] hi;
    logic [2:0][7:0]  rp;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       wr_en = 1'b0;
  logic [1:0] wr_ch = 2'd0;
  logic [1:0] wr_mode = 2'd0;
  logic [7:0] wr_pos = 8'd0;
  logic [1:0] rd_ch = 2'd0;
  logic [7:0] rd_pos;
  logic [2:0] pwm_out;
  logic       frame_start;

  int   vectors = 0;
  int   miscompares = 0;
  exp_t exp_q[$];

  servo_pwm_multi #(
    .CHANNELS(3), .PRESCALE(2), .FRAME_TICKS(400), .BASE_TICKS(50), .SWEEP_STEP(64)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_ch(wr_ch), .wr_mode(wr_mode),
    .wr_pos(wr_pos), .rd_ch(rd_ch), .rd_pos(rd_pos), .pwm_out(pwm_out),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(input int h0, h1, h2, input int r0, r1, r2);
    exp_t e;
    e.hi[0] = 16'(h0); e.hi[1] = 16'(h1); e.hi[2] = 16'(h2);
    e.rp[0] = 8'(r0);  e.rp[1] = 8'(r1);  e.rp[2] = 8'(r2);
    return e;
  endfunction

  // Counts negedges until frame_start, bounded.
  task automatic wait_fs(input string tag, input int expected);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!frame_start && n < 3 * C_FRAME_CYC);
    check(tag, n, expected);
  endtask

  // Entered on a frame_start negedge; measures one frame and leaves on the next.
  task automatic run_frame(input bit do_wr, input int wr_at, input logic [1:0] ch,
                           input logic [1:0] mode, input logic [7:0] pos);
    int hi[3];
    int fs = 0;
    logic [7:0] rp[3];
    exp_t e;
    for (int c = 0; c < 3; c++) hi[c] = 0;
    for (int i = 0; i < C_FRAME_CYC; i++) begin
      wr_en = do_wr && (i == wr_at);
      if (wr_en) begin
        wr_ch = ch; wr_mode = mode; wr_pos = pos;
      end
      if (i == 5) begin
        for (int c = 0; c < 3; c++) begin
          rd_ch = 2'(c);
          #1 rp[c] = rd_pos;
        end
        rd_ch = 2'd3;
        #1 check("rd_out_of_range", rd_pos, 0);
        rd_ch = 2'd0;
      end
      for (int c = 0; c < 3; c++) hi[c] += int'(pwm_out[c]);
      fs += int'(frame_start);
      @(negedge clk);
    end
    wr_en = 1'b0;
    check("frame_period", frame_start, 1);
    check("frame_start_once", fs, 1);
    if (exp_q.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = exp_q.pop_front();
      for (int c = 0; c < 3; c++) begin
        check($sformatf("width_ch%0d", c), hi[c], e.hi[c]);
        check($sformatf("rd_pos_ch%0d", c), rp[c], e.rp[c]);
      end
    end
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check("rst_pwm", pwm_out, 0);
    check("rst_frame_start", frame_start, 0);
    for (int c = 0; c < 3; c++) begin
      rd_ch = 2'(c);
      #1 check($sformatf("rst_rd_pos_ch%0d", c), rd_pos, 128);
    end
    rd_ch = 2'd0;
    rst = 1'b0;
    wait_fs("first_frame_start", 800);

    exp_q.push_back(mk(0, 0, 0, 128, 128, 128));
    run_frame(1'b0, 0, 2'd0, 2'b00, 8'd0);

    // Manual, center, sweep writes each land one frame later
    exp_q.push_back(mk(0, 0, 0, 128, 128, 128));
    run_frame(1'b1, 0, 2'd1, 2'b01, 8'd100);
    exp_q.push_back(mk(0, 300, 0, 128, 100, 128));
    run_frame(1'b1, 0, 2'd0, 2'b10, 8'd7);
    exp_q.push_back(mk(356, 300, 0, 128, 100, 128));
    run_frame(1'b1, 0, 2'd2, 2'b11, 8'd200);

    exp_q.push_back(mk(356, 300, 500, 128, 100, 200));
    exp_q.push_back(mk(356, 300, 610, 128, 100, 255));
    exp_q.push_back(mk(356, 300, 482, 128, 100, 191));
    exp_q.push_back(mk(356, 300, 354, 128, 100, 127));
    exp_q.push_back(mk(356, 300, 226, 128, 100, 63));
    exp_q.push_back(mk(356, 300, 100, 128, 100, 0));
    repeat (6) run_frame(1'b0, 0, 2'd0, 2'b00, 8'd0);

    // Write in the boundary cycle: old width holds one more frame
    exp_q.push_back(mk(356, 300, 228, 128, 100, 64));
    run_frame(1'b1, C_FRAME_CYC - 1, 2'd1, 2'b01, 8'd10);
    exp_q.push_back(mk(356, 300, 356, 128, 100, 128));
    run_frame(1'b0, 0, 2'd0, 2'b00, 8'd0);

    // Out-of-range channel write must not disturb any channel
    exp_q.push_back(mk(356, 120, 484, 128, 10, 192));
    run_frame(1'b1, 0, 2'd3, 2'b00, 8'd0);
    exp_q.push_back(mk(356, 120, 610, 128, 10, 255));
    run_frame(1'b0, 0, 2'd0, 2'b00, 8'd0);

    // Reset mid-pulse with a pending write
    wr_en = 1'b1; wr_ch = 2'd1; wr_mode = 2'b01; wr_pos = 8'd200;
    @(negedge clk);
    wr_en = 1'b0;
    repeat (49) @(negedge clk);
    check("pulse_before_rst", pwm_out, 3'b111);
    rst = 1'b1;
    @(negedge clk);
    check("pwm_after_rst", pwm_out, 0);
    check("fs_after_rst", frame_start, 0);
    @(negedge clk);
    rst = 1'b0;
    wait_fs("frame_start_after_rst", 800);
    exp_q.push_back(mk(0, 0, 0, 128, 128, 128));
    run_frame(1'b0, 0, 2'd0, 2'b00, 8'd0);

    check("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
